// File: rtl/wb_track_pipe_pkg.sv
// Shared write-data source encodings and bubble field values for the write-back tracking pipe.
package wb_track_pipe_pkg;

  localparam logic [1:0] CregAluout = 2'd0;
  localparam logic [1:0] CregMemrd  = 2'd1;
  localparam logic [1:0] CregPc8    = 2'd2;
  localparam logic [1:0] CregLui    = 2'd3;

  // A bubble never writes and selects the ALU so its data path is inert.
  localparam logic       BubbleWe  = 1'b0;
  localparam logic [1:0] BubbleSel = CregAluout;

endpackage

// File: rtl/wb_stage_reg.sv
// Pipeline stage register: synchronous active-low reset and bubble load share the same value.
module wb_stage_reg #(
  parameter int unsigned      Width     = 1,
  parameter logic [Width-1:0] BubbleVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= BubbleVal;
    end else if (bubble) begin
      q <= BubbleVal;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_track_pipe.sv
// Tracks destination-register intent ID->EX->MEM->WB, resolves write data at the earliest
// stage and exposes per-stage forwarding tuples plus a saturating stall counter.
module wb_track_pipe
  import wb_track_pipe_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_we,
  input  logic [AW-1:0] id_wa,
  input  logic [1:0]    id_cregwd,
  input  logic [DW-1:0] id_link,
  input  logic [DW-1:0] id_imm,
  input  logic          pause,
  input  logic          flush,
  input  logic [DW-1:0] ex_alu_y,
  input  logic [DW-1:0] me_rdata,
  output logic          we_ex,
  output logic [AW-1:0] wa_ex,
  output logic [DW-1:0] wd_ex,
  output logic [1:0]    cregwd_ex,
  output logic          we_me,
  output logic [AW-1:0] wa_me,
  output logic [DW-1:0] wd_me,
  output logic          we_wb,
  output logic [AW-1:0] wa_wb,
  output logic [DW-1:0] wd_wb,
  output logic [31:0]   stall_cnt
);

  localparam int unsigned IdExW = 1 + AW + 2 + DW + DW;
  localparam int unsigned ExMeW = 1 + AW + 2 + DW;
  localparam int unsigned MeWbW = 1 + AW + DW;

  localparam logic [IdExW-1:0] IdExBubble = {BubbleWe, {AW{1'b0}}, BubbleSel, {(2*DW){1'b0}}};
  localparam logic [ExMeW-1:0] ExMeBubble = {BubbleWe, {AW{1'b0}}, BubbleSel, {DW{1'b0}}};
  localparam logic [MeWbW-1:0] MeWbBubble = {BubbleWe, {(AW+DW){1'b0}}};

  logic          ex_we;
  logic [AW-1:0] ex_wa;
  logic [1:0]    ex_sel;
  logic [DW-1:0] ex_link;
  logic [DW-1:0] ex_imm;
  logic          me_we;
  logic [AW-1:0] me_wa;
  logic [1:0]    me_sel;
  logic [DW-1:0] me_val;
  logic [31:0]   stall_cnt_q;

  // $0 is hardwired: qualify the enable once so no downstream stage ever forwards it.
  logic id_we_q;
  assign id_we_q = id_we && (id_wa != '0);

  wb_stage_reg #(
    .Width    (IdExW),
    .BubbleVal(IdExBubble)
  ) u_id_ex (
    .clk   (clk),
    .rst   (rst),
    .bubble(pause | flush),
    .d     ({id_we_q, id_wa, id_cregwd, id_link, id_imm}),
    .q     ({ex_we, ex_wa, ex_sel, ex_link, ex_imm})
  );

  always_comb begin
    wd_ex = '0;
    unique case (ex_sel)
      CregAluout: wd_ex = ex_alu_y;
      CregPc8:    wd_ex = ex_link;
      CregLui:    wd_ex = ex_imm;
      default:    wd_ex = '0;
    endcase
  end

  assign we_ex     = ex_we;
  assign wa_ex     = ex_wa;
  assign cregwd_ex = ex_sel;

  wb_stage_reg #(
    .Width    (ExMeW),
    .BubbleVal(ExMeBubble)
  ) u_ex_me (
    .clk   (clk),
    .rst   (rst),
    .bubble(1'b0),
    .d     ({ex_we, ex_wa, ex_sel, wd_ex}),
    .q     ({me_we, me_wa, me_sel, me_val})
  );

  assign wd_me = (me_sel == CregMemrd) ? me_rdata : me_val;
  assign we_me = me_we;
  assign wa_me = me_wa;

  wb_stage_reg #(
    .Width    (MeWbW),
    .BubbleVal(MeWbBubble)
  ) u_me_wb (
    .clk   (clk),
    .rst   (rst),
    .bubble(1'b0),
    .d     ({me_we, me_wa, wd_me}),
    .q     ({we_wb, wa_wb, wd_wb})
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (pause && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_wb_track_pipe.sv
// Directed bench for wb_track_pipe with hand-computed expectations.
module tb_wb_track_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_we;
  logic [AW-1:0] id_wa;
  logic [1:0]    id_cregwd;
  logic [DW-1:0] id_link;
  logic [DW-1:0] id_imm;
  logic          pause;
  logic          flush;
  logic [DW-1:0] ex_alu_y;
  logic [DW-1:0] me_rdata;
  logic          we_ex;
  logic [AW-1:0] wa_ex;
  logic [DW-1:0] wd_ex;
  logic [1:0]    cregwd_ex;
  logic          we_me;
  logic [AW-1:0] wa_me;
  logic [DW-1:0] wd_me;
  logic          we_wb;
  logic [AW-1:0] wa_wb;
  logic [DW-1:0] wd_wb;
  logic [31:0]   stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_track_pipe #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .id_we    (id_we),
    .id_wa    (id_wa),
    .id_cregwd(id_cregwd),
    .id_link  (id_link),
    .id_imm   (id_imm),
    .pause    (pause),
    .flush    (flush),
    .ex_alu_y (ex_alu_y),
    .me_rdata (me_rdata),
    .we_ex    (we_ex),
    .wa_ex    (wa_ex),
    .wd_ex    (wd_ex),
    .cregwd_ex(cregwd_ex),
    .we_me    (we_me),
    .wa_me    (wa_me),
    .wd_me    (wd_me),
    .we_wb    (we_wb),
    .wa_wb    (wa_wb),
    .wd_wb    (wd_wb),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_issue(input logic we, input logic [AW-1:0] wa, input logic [1:0] sel,
                          input logic [DW-1:0] link, input logic [DW-1:0] imm);
    id_we     = we;
    id_wa     = wa;
    id_cregwd = sel;
    id_link   = link;
    id_imm    = imm;
  endtask

  task automatic id_clear();
    id_issue(1'b0, '0, 2'd0, '0, '0);
  endtask

  initial begin
    rst      = 1'b0;
    pause    = 1'b0;
    flush    = 1'b0;
    ex_alu_y = '0;
    me_rdata = '0;
    id_clear();
    tick();
    tick();
    check("rst_we_ex", {31'd0, we_ex}, 32'd0);
    check("rst_wd_ex", wd_ex, 32'd0);
    check("rst_we_wb", {31'd0, we_wb}, 32'd0);
    check("rst_stall", stall_cnt, 32'd0);
    rst = 1'b1;

    // ALU chain
    id_issue(1'b1, 5'd5, 2'd0, '0, '0);
    tick();
    id_clear();
    ex_alu_y = 32'h0000_1234;
    #1;
    check("alu_we_ex", {31'd0, we_ex}, 32'd1);
    check("alu_wa_ex", {27'd0, wa_ex}, 32'd5);
    check("alu_wd_ex", wd_ex, 32'h0000_1234);
    tick();
    ex_alu_y = '0;
    #1;
    check("alu_we_me", {31'd0, we_me}, 32'd1);
    check("alu_wd_me", wd_me, 32'h0000_1234);
    tick();
    check("alu_we_wb", {31'd0, we_wb}, 32'd1);
    check("alu_wa_wb", {27'd0, wa_wb}, 32'd5);
    check("alu_wd_wb", wd_wb, 32'h0000_1234);

    // Load-use
    id_issue(1'b1, 5'd8, 2'd1, '0, '0);
    tick();
    id_clear();
    check("ld_sel_ex", {30'd0, cregwd_ex}, 32'd1);
    check("ld_we_ex", {31'd0, we_ex}, 32'd1);
    check("ld_wd_ex", wd_ex, 32'd0);
    pause = 1'b1;
    tick();
    pause = 1'b0;
    check("ld_bubble_we_ex", {31'd0, we_ex}, 32'd0);
    check("ld_we_me", {31'd0, we_me}, 32'd1);
    check("ld_wa_me", {27'd0, wa_me}, 32'd8);
    me_rdata = 32'hCAFE_F00D;
    #1;
    check("ld_wd_me", wd_me, 32'hCAFE_F00D);
    check("ld_stall", stall_cnt, 32'd1);
    tick();
    me_rdata = '0;
    #1;
    check("ld_wd_wb", wd_wb, 32'hCAFE_F00D);
    check("ld_wa_wb", {27'd0, wa_wb}, 32'd8);

    // Register $0
    id_issue(1'b1, 5'd0, 2'd0, '0, '0);
    ex_alu_y = 32'h55;
    tick();
    id_clear();
    check("r0_we_ex", {31'd0, we_ex}, 32'd0);
    tick();
    check("r0_we_me", {31'd0, we_me}, 32'd0);
    tick();
    check("r0_we_wb", {31'd0, we_wb}, 32'd0);
    ex_alu_y = '0;

    // Link and LUI
    id_issue(1'b1, 5'd31, 2'd2, 32'h0040_0010, '0);
    tick();
    id_issue(1'b1, 5'd2, 2'd3, '0, 32'hABCD_0000);
    check("lnk_wd_ex", wd_ex, 32'h0040_0010);
    check("lnk_wa_ex", {27'd0, wa_ex}, 32'd31);
    tick();
    id_clear();
    check("lnk_wd_me", wd_me, 32'h0040_0010);
    check("lui_wd_ex", wd_ex, 32'hABCD_0000);
    tick();
    check("lnk_wd_wb", wd_wb, 32'h0040_0010);
    check("lui_wd_me", wd_me, 32'hABCD_0000);

    // Flush, then pause+flush together
    id_issue(1'b1, 5'd9, 2'd0, '0, '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_we_ex", {31'd0, we_ex}, 32'd0);
    id_issue(1'b1, 5'd10, 2'd0, '0, '0);
    pause = 1'b1;
    flush = 1'b1;
    tick();
    pause = 1'b0;
    flush = 1'b0;
    check("pf_we_ex", {31'd0, we_ex}, 32'd0);
    check("pf_stall", stall_cnt, 32'd2);
    tick();
    check("pf_resume_wa_ex", {27'd0, wa_ex}, 32'd10);
    id_clear();

    // Reset mid-stream with three instructions in flight
    ex_alu_y = 32'h11;
    me_rdata = 32'h22;
    id_issue(1'b1, 5'd11, 2'd0, '0, '0);
    tick();
    id_issue(1'b1, 5'd12, 2'd0, '0, '0);
    tick();
    id_issue(1'b1, 5'd13, 2'd0, '0, '0);
    tick();
    id_clear();
    check("rm_pre_wa_wb", {27'd0, wa_wb}, 32'd11);
    rst = 1'b0;
    tick();
    ex_alu_y = '0;
    me_rdata = '0;
    #1;
    check("rm_we_all", {29'd0, we_ex, we_me, we_wb}, 32'd0);
    check("rm_wa_all", {17'd0, wa_ex, wa_me, wa_wb}, 32'd0);
    check("rm_wd_ex", wd_ex, 32'd0);
    check("rm_wd_me", wd_me, 32'd0);
    check("rm_wd_wb", wd_wb, 32'd0);
    check("rm_stall", stall_cnt, 32'd0);
    rst = 1'b1;

    // Saturation via preload
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    pause = 1'b1;
    tick();
    check("sat_first", stall_cnt, 32'hFFFF_FFFF);
    tick();
    tick();
    pause = 1'b0;
    check("sat_hold", stall_cnt, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
